// File: rtl/fpr_wb_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fpr_wb_arbiter_pkg
// Description : Shared floating-point register file constants and the packed
//               write-back request type used by the FP write-back arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package fpr_wb_arbiter_pkg;

    localparam int FPR_ADDR_W = 5;
    localparam int FPR_DATA_W = 32;
    localparam int FPR_NREGS  = 32;

    // One write-back request: destination register and result value.
    typedef struct packed {
        logic [FPR_ADDR_W-1:0] wa;
        logic [FPR_DATA_W-1:0] data;
    } fpr_wb_req_t;

endpackage
`default_nettype wire

// File: rtl/fpr_wb_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Round-robin grant generator. The search starts one past
//               i_ptr and wraps modulo N; the first requester found wins.
// Ports       : i_req       - request vector (N bits)
//               i_ptr       - index of the last granted requester
//               o_grant     - one-hot grant (all zero when nothing requests)
//               o_grant_idx - binary index of the granted requester
//               o_any       - a grant was issued
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N     = 4,
    parameter int PTR_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     i_req,
    input  logic [PTR_W-1:0] i_ptr,
    output logic [N-1:0]     o_grant,
    output logic [PTR_W-1:0] o_grant_idx,
    output logic             o_any
);

    logic [PTR_W-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = '0;
        // k = N lands back on i_ptr itself, so the last holder is checked last.
        for (int k = 1; k <= N; k++) begin
            w_cand = PTR_W'((int'(i_ptr) + k) % N);
            if (!o_any && i_req[w_cand]) begin
                o_any           = 1'b1;
                o_grant[w_cand] = 1'b1;
                o_grant_idx     = w_cand;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/fpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : fpr_wb_arbiter
// Description : Write-back arbiter and pending-write scoreboard for the
//               32x32 FP register file. Picks one producer result per cycle
//               (round robin), registers it onto the single write port and
//               tracks a per-register busy vector for the issue stage.
// Ports       : clk, rst (sync, active-low), flush
//               src_valid/src_ready/src_wa/src_data - producer handshake
//               iss_valid/iss_rd                    - FP-destination issue
//               reg_write/wa/data_write             - register file port
//               busy                                - pending-write vector
//               fwd_valid/fwd_wa/fwd_data           - forwarding tap
// Config      : FPR_WB_FWD_EN - when defined, fwd_* carry the granted result
//               combinationally in the grant cycle; otherwise tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
module fpr_wb_arbiter
    import fpr_wb_arbiter_pkg::*;
#(
    parameter int NUM_SRC = 4,
    parameter int DATA_W  = FPR_DATA_W,
    parameter int ADDR_W  = FPR_ADDR_W
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      flush,
    input  logic [NUM_SRC-1:0]        src_valid,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic [NUM_SRC*ADDR_W-1:0] src_wa,
    input  logic [NUM_SRC*DATA_W-1:0] src_data,
    input  logic                      iss_valid,
    input  logic [ADDR_W-1:0]         iss_rd,
    output logic                      reg_write,
    output logic [ADDR_W-1:0]         wa,
    output logic [DATA_W-1:0]         data_write,
    output logic [FPR_NREGS-1:0]      busy,
    output logic                      fwd_valid,
    output logic [ADDR_W-1:0]         fwd_wa,
    output logic [DATA_W-1:0]         fwd_data
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
    // Resetting the pointer to the last index gives source 0 first priority.
    localparam logic [PTR_W-1:0] c_PTR_RST = PTR_W'(NUM_SRC - 1);

    logic [ADDR_W-1:0]    w_src_wa   [NUM_SRC];
    logic [DATA_W-1:0]    w_src_data [NUM_SRC];
    logic [NUM_SRC-1:0]   w_req;
    logic [NUM_SRC-1:0]   w_grant;
    logic [PTR_W-1:0]     w_gidx;
    logic                 w_any;
    fpr_wb_req_t          w_sel;

    logic [PTR_W-1:0]     r_ptr,       w_ptr_nxt;
    logic                 r_reg_write, w_reg_write_nxt;
    fpr_wb_req_t          r_wb,        w_wb_nxt;
    logic [FPR_NREGS-1:0] r_busy,      w_busy_nxt;

    for (genvar i = 0; i < NUM_SRC; i++) begin : g_unpack
        assign w_src_wa[i]   = src_wa[i*ADDR_W +: ADDR_W];
        assign w_src_data[i] = src_data[i*DATA_W +: DATA_W];
    end

    // No grant during flush; none during reset either, so a producer never
    // sees a transfer that the reset then discards.
    assign w_req = (flush || !rst) ? '0 : src_valid;

    rr_arbiter #(
        .N     (NUM_SRC),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req       (w_req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any       (w_any)
    );

    assign src_ready = w_grant;
    assign w_sel     = '{wa: w_src_wa[w_gidx], data: w_src_data[w_gidx]};

    always_comb begin
        w_ptr_nxt       = r_ptr;
        w_reg_write_nxt = 1'b0;
        w_wb_nxt        = r_wb;
        if (w_any) begin
            w_ptr_nxt       = w_gidx;
            // f0 is hard-wired: the result is consumed but never written.
            w_reg_write_nxt = (w_sel.wa != '0);
            w_wb_nxt        = w_sel;
        end
    end

    always_comb begin
        w_busy_nxt = r_busy;
        if (r_reg_write) begin
            w_busy_nxt[r_wb.wa] = 1'b0;
        end
        // Set after clear: a newer issue to the same register owns it.
        if (iss_valid && (iss_rd != '0)) begin
            w_busy_nxt[iss_rd] = 1'b1;
        end
        if (flush) begin
            w_busy_nxt = '0;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_ptr       <= c_PTR_RST;
            r_reg_write <= 1'b0;
            r_wb        <= '0;
            r_busy      <= '0;
        end else begin
            r_ptr       <= w_ptr_nxt;
            r_reg_write <= w_reg_write_nxt;
            r_wb        <= w_wb_nxt;
            r_busy      <= w_busy_nxt;
        end
    end

    assign reg_write  = r_reg_write;
    assign wa         = r_wb.wa;
    assign data_write = r_wb.data;
    assign busy       = r_busy;

`ifdef FPR_WB_FWD_EN
    // w_any already excludes flush and reset cycles.
    assign fwd_valid = w_any && (w_sel.wa != '0);
    assign fwd_wa    = w_any ? w_sel.wa   : '0;
    assign fwd_data  = w_any ? w_sel.data : '0;
`else
    assign fwd_valid = 1'b0;
    assign fwd_wa    = '0;
    assign fwd_data  = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fpr_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_fpr_wb_arbiter
// Description : Directed self-checking bench for fpr_wb_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fpr_wb_arbiter;

    localparam int NS = 4;
    localparam int AW = 5;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              flush;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*AW-1:0]  src_wa;
    logic [NS*DW-1:0]  src_data;
    logic              iss_valid;
    logic [AW-1:0]     iss_rd;
    logic              reg_write;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     data_write;
    logic [31:0]       busy;
    logic              fwd_valid;
    logic [AW-1:0]     fwd_wa;
    logic [DW-1:0]     fwd_data;

    int n_vec  = 0;
    int n_fail = 0;

    fpr_wb_arbiter #(
        .NUM_SRC (NS),
        .DATA_W  (DW),
        .ADDR_W  (AW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .src_valid  (src_valid),
        .src_ready  (src_ready),
        .src_wa     (src_wa),
        .src_data   (src_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .reg_write  (reg_write),
        .wa         (wa),
        .data_write (data_write),
        .busy       (busy),
        .fwd_valid  (fwd_valid),
        .fwd_wa     (fwd_wa),
        .fwd_data   (fwd_data)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_src(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_wa[i*AW +: AW]   = a;
        src_data[i*DW +: DW] = d;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b0;
        flush     = 1'b0;
        src_valid = '0;
        src_wa    = '0;
        src_data  = '0;
        iss_valid = 1'b0;
        iss_rd    = '0;
        tick(); tick(); tick();

        // Reset state
        check("rst_reg_write", reg_write, 0);
        check("rst_wa", wa, 0);
        check("rst_data", data_write, 0);
        check("rst_busy", busy, 0);
        check("rst_fwd_valid", fwd_valid, 0);
        rst = 1'b1;
        tick();

        // All four sources valid: grants 0,1,2,3 in order after reset
        for (int i = 0; i < NS; i++) set_src(i, AW'(i + 1), 32'hA000_0000 + DW'(i));
        src_valid = 4'hF;
        for (int k = 0; k < NS; k++) begin
            #1;
            check("rr_grant", src_ready, 64'(1 << k));
            tick();
            src_valid[k] = 1'b0;
            check("rr_reg_write", reg_write, 1);
            check("rr_wa", wa, k + 1);
            check("rr_data", data_write, 32'hA000_0000 + k);
        end
        tick();
        check("rr_idle_reg_write", reg_write, 0);
        check("rr_idle_wa_hold", wa, 4);

        // Single source: issue to f5, then source 1 returns it
        iss_valid = 1'b1; iss_rd = 5'd5;
        tick();
        iss_valid = 1'b0;
        check("iss_busy5", busy, 32'h0000_0020);
        set_src(1, 5'd5, 32'h3F80_0000);
        src_valid = 4'b0010;
        #1;
        check("single_ready", src_ready, 4'b0010);
`ifdef FPR_WB_FWD_EN
        check("single_fwd_valid", fwd_valid, 1);
        check("single_fwd_wa", fwd_wa, 5);
        check("single_fwd_data", fwd_data, 32'h3F80_0000);
`else
        check("single_fwd_off", fwd_valid, 0);
`endif
        tick();
        src_valid = '0;
        check("single_reg_write", reg_write, 1);
        check("single_wa", wa, 5);
        check("single_data", data_write, 32'h3F80_0000);
        check("single_busy_still", busy, 32'h0000_0020);
        tick();
        check("single_done_reg_write", reg_write, 0);
        check("single_busy_clear", busy, 0);

        // Set wins over clear on the same register and edge (ptr=1 -> src 2)
        iss_valid = 1'b1; iss_rd = 5'd7;
        tick();
        iss_valid = 1'b0;
        check("iss_busy7", busy, 32'h0000_0080);
        set_src(2, 5'd7, 32'h4000_0000);
        src_valid = 4'b0100;
        #1;
        check("setwin_ready", src_ready, 4'b0100);
        tick();
        src_valid = '0;
        iss_valid = 1'b1; iss_rd = 5'd7;
        check("setwin_reg_write", reg_write, 1);
        check("setwin_wa", wa, 7);
        tick();
        iss_valid = 1'b0;
        check("setwin_busy7", busy, 32'h0000_0080);
        tick();
        check("setwin_busy_hold", busy, 32'h0000_0080);
        check("setwin_idle", reg_write, 0);

        // Destination f0: consumed, never written, busy[0] stays 0 (ptr=2 -> src 3)
        set_src(3, 5'd0, 32'hDEAD_BEEF);
        src_valid = 4'b1000;
        #1;
        check("f0_ready", src_ready, 4'b1000);
        check("f0_fwd_valid", fwd_valid, 0);
        tick();
        src_valid = '0;
        check("f0_reg_write", reg_write, 0);
        check("f0_busy", busy, 32'h0000_0080);

        // Flush with busy=0xF0 and sources 2,3 valid (ptr=3)
        iss_valid = 1'b1;
        iss_rd = 5'd4; tick();
        iss_rd = 5'd5; tick();
        iss_rd = 5'd6; tick();
        iss_valid = 1'b0;
        check("flush_pre_busy", busy, 32'h0000_00F0);
        set_src(2, 5'd9,  32'h0000_0011);
        set_src(3, 5'd10, 32'h0000_0022);
        src_valid = 4'b1100;
        flush = 1'b1;
        iss_valid = 1'b1; iss_rd = 5'd12;
        #1;
        check("flush_ready", src_ready, 0);
        check("flush_fwd_valid", fwd_valid, 0);
        tick();
        flush = 1'b0;
        iss_valid = 1'b0;
        check("flush_busy", busy, 0);
        check("flush_reg_write", reg_write, 0);
        #1;
        check("flush_next_grant", src_ready, 4'b0100);
        tick();
        src_valid = 4'b1000;
        check("flush_wr9", wa, 9);
        check("flush_wr9_en", reg_write, 1);
        #1;
        check("flush_grant3", src_ready, 4'b1000);
        tick();
        src_valid = '0;
        check("flush_wr10", wa, 10);
        check("flush_wr10_data", data_write, 32'h0000_0022);

        // Reset mid-stream: grant 0 then 1, then reset; source 0 wins again after
        for (int i = 0; i < NS; i++) set_src(i, AW'(i + 1), 32'hB000_0000 + DW'(i));
        src_valid = 4'hF;
        iss_valid = 1'b1; iss_rd = 5'd3;
        #1;
        check("mid_grant0", src_ready, 4'b0001);
        tick();
        iss_valid = 1'b0;
        check("mid_grant1", src_ready, 4'b0010);
        tick();
        check("mid_busy_pre", busy, 32'h0000_0008);
        rst = 1'b0;
        tick();
        check("mid_rst_reg_write", reg_write, 0);
        check("mid_rst_wa", wa, 0);
        check("mid_rst_data", data_write, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_ready", src_ready, 0);
        check("mid_rst_fwd", fwd_valid, 0);
        rst = 1'b1;
        #1;
        check("post_rst_grant0", src_ready, 4'b0001);
`ifdef FPR_WB_FWD_EN
        check("post_rst_fwd_data", fwd_data, 32'hB000_0000);
        check("post_rst_fwd_wa", fwd_wa, 1);
`endif
        tick();
        src_valid = '0;
        check("post_rst_wa", wa, 1);
        check("post_rst_data", data_write, 32'hB000_0000);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
